// File: rtl/mul_product_acc.sv
// Sums N products from the right-shift multiplier and hands each sum out over valid/ready.
// A one-entry skid and a sticky ovf flag absorb products that arrive while a sum is held.
// Ports: clk, rst_n, done, result, clr, out_ready -> out_valid, acc_out, ovf (+ sat).
// Option: MUL_PRODUCT_ACC_SAT_EN makes additions saturate and adds the sticky sat output.
module mul_product_acc #(
  parameter int k     = 3,
  parameter int N     = 4,
  parameter int ACC_W = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    done,
  input  logic signed [2*k:0]     result,
  input  logic                    clr,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] acc_out,
`ifdef MUL_PRODUCT_ACC_SAT_EN
  output logic                    sat,
`endif
  output logic                    ovf
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  state_t                  r_state, w_state;
  logic signed [ACC_W-1:0] r_acc, w_acc;
  logic signed [ACC_W-1:0] r_skid, w_skid;
  logic                    r_skid_v, w_skid_v;
  logic [CW-1:0]           r_cnt, w_cnt;
  logic                    r_done_q;
  logic                    r_out_valid, w_out_valid;
  logic signed [ACC_W-1:0] r_acc_out, w_acc_out;
  logic                    r_ovf, w_ovf;
  logic                    r_sat, w_sat;

  logic                    w_cap;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_res;
  logic                    w_clamp;

  assign w_cap = done & ~r_done_q;
  assign w_ext = result;

  // A fresh capture always wins; the skid drains only in idle cycles.
  assign w_term = w_cap ? w_ext : r_skid;

`ifdef MUL_PRODUCT_ACC_SAT_EN
  logic signed [ACC_W:0] w_sum;
  assign w_sum   = {r_acc[ACC_W-1], r_acc} + {w_term[ACC_W-1], w_term};
  assign w_clamp = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  always_comb begin
    w_res = w_sum[ACC_W-1:0];
    if (w_clamp) begin
      w_res = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
  assign sat = r_sat;
`else
  assign w_res   = r_acc + w_term;
  assign w_clamp = 1'b0;
`endif

  always_comb begin
    w_state     = r_state;
    w_acc       = r_acc;
    w_cnt       = r_cnt;
    w_skid      = r_skid;
    w_skid_v    = r_skid_v;
    w_out_valid = r_out_valid;
    w_acc_out   = r_acc_out;
    w_ovf       = r_ovf;
    w_sat       = r_sat;
    if (clr) begin
      w_state     = ACC;
      w_acc       = '0;
      w_cnt       = '0;
      w_skid_v    = 1'b0;
      w_out_valid = 1'b0;
      w_ovf       = 1'b0;
      w_sat       = 1'b0;
    end else begin
      unique case (r_state)
        ACC: begin
          if (w_cap || r_skid_v) begin
            // A cap with a full skid leaves it full for the next cycle.
            if (!w_cap) w_skid_v = 1'b0;
            w_acc = w_res;
            w_cnt = r_cnt + 1'b1;
            if (w_clamp) w_sat = 1'b1;
            if (r_cnt == CW'(N - 1)) begin
              w_state     = HOLD;
              w_out_valid = 1'b1;
              w_acc_out   = w_res;
            end
          end
        end
        HOLD: begin
          if (w_cap) begin
            if (!r_skid_v) begin
              w_skid   = w_ext;
              w_skid_v = 1'b1;
            end else begin
              w_ovf = 1'b1;
            end
          end
          if (out_ready) begin
            w_state     = ACC;
            w_out_valid = 1'b0;
            w_acc       = '0;
            w_cnt       = '0;
            w_sat       = 1'b0;
          end
        end
        default: begin
          w_state = ACC;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_skid      <= '0;
      r_skid_v    <= 1'b0;
      r_done_q    <= 1'b0;
      r_out_valid <= 1'b0;
      r_acc_out   <= '0;
      r_ovf       <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_acc       <= w_acc;
      r_cnt       <= w_cnt;
      r_skid      <= w_skid;
      r_skid_v    <= w_skid_v;
      r_done_q    <= done;
      r_out_valid <= w_out_valid;
      r_acc_out   <= w_acc_out;
      r_ovf       <= w_ovf;
      r_sat       <= w_sat;
    end
  end

  assign out_valid = r_out_valid;
  assign acc_out   = r_acc_out;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_mul_product_acc.sv
// Directed bench for mul_product_acc.
// Runs a 9-bit and a 7-bit accumulator side by side on shared stimulus.
module tb_mul_product_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done;
  logic [6:0] res;
  logic       clr;
  logic       out_ready;

  logic       ov9, ovf9;
  logic [8:0] acc9;
  logic       ov7, ovf7;
  logic [6:0] acc7;
`ifdef MUL_PRODUCT_ACC_SAT_EN
  logic       sat9, sat7;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_product_acc #(.k(3), .N(4), .ACC_W(9)) dut9 (
    .clk       (clk),
    .rst_n     (rst_n),
    .done      (done),
    .result    (res),
    .clr       (clr),
    .out_ready (out_ready),
    .out_valid (ov9),
    .acc_out   (acc9),
`ifdef MUL_PRODUCT_ACC_SAT_EN
    .sat       (sat9),
`endif
    .ovf       (ovf9)
  );

  mul_product_acc #(.k(3), .N(4), .ACC_W(7)) dut7 (
    .clk       (clk),
    .rst_n     (rst_n),
    .done      (done),
    .result    (res),
    .clr       (clr),
    .out_ready (out_ready),
    .out_valid (ov7),
    .acc_out   (acc7),
`ifdef MUL_PRODUCT_ACC_SAT_EN
    .sat       (sat7),
`endif
    .ovf       (ovf7)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int v);
    res  = v[6:0];
    done = 1'b1;
    step();
    done = 1'b0;
    step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    done      = 1'b0;
    res       = '0;
    clr       = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", {31'b0, ov9}, 32'd0);
    chk("rst_acc", {23'b0, acc9}, 32'd0);
    chk("rst_ovf", {31'b0, ovf9}, 32'd0);
    rst_n = 1'b1;
    step();

    // Basic sum 6 - 3 + 16 - 4 = 15
    pulse(6);
    pulse(-3);
    pulse(16);
    chk("basic_pre_valid", {31'b0, ov9}, 32'd0);
    res  = 7'h7C;
    done = 1'b1;
    step();
    chk("basic_valid", {31'b0, ov9}, 32'd1);
    chk("basic_acc", {23'b0, acc9}, 32'h00F);
    done = 1'b0;
    handshake();
    chk("basic_hs_valid", {31'b0, ov9}, 32'd0);
    chk("basic_keep_acc", {23'b0, acc9}, 32'h00F);

    // Level done: four 5-cycle highs give four captures
    for (int g = 0; g < 4; g++) begin
      res  = 7'd5;
      done = 1'b1;
      repeat (5) step();
      done = 1'b0;
      step();
    end
    chk("level_valid", {31'b0, ov9}, 32'd1);
    chk("level_acc", {23'b0, acc9}, 32'd20);
    chk("level_ovf", {31'b0, ovf9}, 32'd0);
    handshake();

    // Backpressure: 7 goes to skid, 2 is dropped
    pulse(1);
    pulse(1);
    pulse(1);
    pulse(1);
    chk("bp_acc", {23'b0, acc9}, 32'd4);
    pulse(7);
    chk("bp_no_ovf_yet", {31'b0, ovf9}, 32'd0);
    pulse(2);
    chk("bp_ovf", {31'b0, ovf9}, 32'd1);
    chk("bp_valid", {31'b0, ov9}, 32'd1);
    chk("bp_acc_frozen", {23'b0, acc9}, 32'd4);
    handshake();
    chk("bp_hs_valid", {31'b0, ov9}, 32'd0);
    pulse(1);
    pulse(1);
    pulse(1);
    chk("bp_skid_sum_valid", {31'b0, ov9}, 32'd1);
    chk("bp_skid_sum", {23'b0, acc9}, 32'd10);
    handshake();

    // Clear after two products; cap in the clr cycle is discarded
    pulse(3);
    pulse(3);
    res  = 7'd9;
    done = 1'b1;
    clr  = 1'b1;
    step();
    done = 1'b0;
    clr  = 1'b0;
    step();
    chk("clr_ovf", {31'b0, ovf9}, 32'd0);
    chk("clr_valid", {31'b0, ov9}, 32'd0);
    chk("clr_acc_kept", {23'b0, acc9}, 32'd10);
    pulse(1);
    pulse(2);
    pulse(3);
    chk("clr_three_valid", {31'b0, ov9}, 32'd0);
    pulse(-1);
    chk("clr_sum_valid", {31'b0, ov9}, 32'd1);
    chk("clr_sum", {23'b0, acc9}, 32'd5);
    handshake();

    // Asynchronous reset while holding a sum
    pulse(2);
    pulse(2);
    pulse(2);
    pulse(2);
    chk("hold_acc", {23'b0, acc9}, 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, ov9}, 32'd0);
    chk("arst_acc", {23'b0, acc9}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Four products of 16: wraps in 7 bits, fits in 9 bits
    pulse(16);
    pulse(16);
    pulse(16);
    pulse(16);
    chk("wrap7_valid", {31'b0, ov7}, 32'd1);
    chk("wrap9_acc", {23'b0, acc9}, 32'd64);
    chk("wrap7_ovf", {31'b0, ovf7}, 32'd0);
`ifdef MUL_PRODUCT_ACC_SAT_EN
    chk("sat7_acc", {25'b0, acc7}, 32'h3F);
    chk("sat7_flag", {31'b0, sat7}, 32'd1);
    chk("sat9_flag", {31'b0, sat9}, 32'd0);
    handshake();
    chk("sat7_hs_clear", {31'b0, sat7}, 32'd0);
`else
    chk("wrap7_acc", {25'b0, acc7}, 32'h40);
    handshake();
`endif
    chk("wrap_hs_valid", {31'b0, ov7}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
